// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default frame sizing
// and line levels for the start and stop bits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_t;

    localparam int UART_DATA_W           = 8;
    localparam int UART_CLKS_PER_BIT_DEF = 434;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and raises tick_o on the
// terminal count. Restarts from zero after the terminal count or whenever
// the owner requests a clear (e.g. on a state change).
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == TERM);

    // Advance the count, restarting on clear or at the end of a bit period.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART 8N1 transmitter. Pops bytes from the TX FIFO (whose data output is
// registered, hence the LATCH state) and shifts them out LSB first between a
// start bit and a stop bit. All outputs are Moore decodes of registers.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int DATA_W       = UART_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_tx_engine: CLKS_PER_BIT must be at least 4");
    end

    tx_state_t         state_q;
    tx_state_t         state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [BIT_W-1:0]  bit_cnt_d;
    logic              baud_tick;
    logic              pop_ok;

    assign pop_ok = tx_en && !fifo_empty;

    // Baud counter restarts on every state change so each state begins a
    // fresh bit period.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk_i   (clk),
        .reset_ni(reset),
        .clr_i   (state_d != state_q),
        .tick_o  (baud_tick)
    );

    // State register; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a pop is only ever issued when enabled and non-empty,
    // and a frame in flight always runs to the end of its stop bit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pop_ok) state_d = POP;
            POP:     state_d = LATCH;
            LATCH:   state_d = START;
            START:   if (baud_tick) state_d = DATA;
            DATA:    if (baud_tick && (bit_cnt_q == LAST_BIT)) state_d = STOP;
            STOP:    if (baud_tick) state_d = pop_ok ? POP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift register and bit counter updates.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            LATCH: begin
                shift_d   = fifo_data;
                bit_cnt_d = '0;
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BIT_W'(1);
                end
            end
            default: bit_cnt_d = '0;
        endcase
    end

    // Datapath registers, cleared on reset so a lost byte leaves no residue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Output decode from state and registered counters only.
    always_comb begin
        tx         = STOP_BIT;
        fifo_rd_en = 1'b0;
        tx_done    = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            POP:     fifo_rd_en = 1'b1;
            START:   tx = START_BIT;
            DATA:    tx = shift_q[0];
            STOP:    tx_done = baud_tick;
            default: ;
        endcase
    end

endmodule
